// File: rtl/vram_dp.sv
// Dual-port RGB frame buffer: host read/write port A, 2-stage scanout port B, fill engine.
// Define VRAM_COLLISION_FWD_EN to forward same-cycle write data to a colliding port B read.
module vram_dp #(
   parameter int CH_W   = 1,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ENA,
   input  logic              WEA,
   input  logic              SSRA,
   input  logic [ADDR_W-1:0] ADDRA,
   input  logic [CH_W-1:0]   DIA_R,
   input  logic [CH_W-1:0]   DIA_G,
   input  logic [CH_W-1:0]   DIA_B,
   output logic [CH_W-1:0]   DOA_R,
   output logic [CH_W-1:0]   DOA_G,
   output logic [CH_W-1:0]   DOA_B,
   input  logic              ENB,
   input  logic [ADDR_W-1:0] ADDRB,
   output logic [CH_W-1:0]   DOB_R,
   output logic [CH_W-1:0]   DOB_G,
   output logic [CH_W-1:0]   DOB_B,
   input  logic              FILL_START,
   input  logic [CH_W-1:0]   FILL_R,
   input  logic [CH_W-1:0]   FILL_G,
   input  logic [CH_W-1:0]   FILL_B,
   output logic              FILL_BUSY,
   output logic              FILL_DONE
);

   localparam int DW    = 3 * CH_W;
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] faddr_q, faddr_d;
   logic [DW-1:0]     fcol_q, fcol_d;

   logic [DW-1:0]     mem [DEPTH];
   logic [DW-1:0]     doa_q, dob_q, rdb_q, rdb_d;

   logic              busy;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DW-1:0]     wdata;

   assign busy = (state_q == FILL);

   always_comb begin
      state_d = state_q;
      faddr_d = faddr_q;
      fcol_d  = fcol_q;
      unique case (state_q)
         IDLE: begin
            if (FILL_START) begin
               fcol_d  = {FILL_R, FILL_G, FILL_B};
               faddr_d = '0;
               state_d = FILL;
            end
         end
         FILL: begin
            // counter parks on the last word instead of wrapping
            if (faddr_q == '1) state_d = DONE;
            else               faddr_d = faddr_q + 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         faddr_q <= '0;
         fcol_q  <= '0;
      end else begin
         state_q <= state_d;
         faddr_q <= faddr_d;
         fcol_q  <= fcol_d;
      end
   end

   // single write port shared by the fill engine and the host
   always_comb begin
      we    = 1'b0;
      waddr = ADDRA;
      wdata = {DIA_R, DIA_G, DIA_B};
      if (busy) begin
         we    = 1'b1;
         waddr = faddr_q;
         wdata = fcol_q;
      end else if (ENA && WEA) begin
         we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

`ifdef VRAM_COLLISION_FWD_EN
   always_comb begin
      rdb_d = mem[ADDRB];
      if (we && (waddr == ADDRB)) rdb_d = wdata;
   end
`else
   always_comb begin
      rdb_d = mem[ADDRB];
   end
`endif

   always_ff @(posedge clk) begin
      if (ENB) rdb_q <= rdb_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         doa_q <= '0;
         dob_q <= '0;
      end else begin
         if (ENA) doa_q <= SSRA ? '0 : mem[ADDRA];
         if (ENB) dob_q <= rdb_q;
      end
   end

   assign {DOA_R, DOA_G, DOA_B} = doa_q;
   assign {DOB_R, DOB_G, DOB_B} = dob_q;
   assign FILL_BUSY = busy;
   assign FILL_DONE = (state_q == DONE);

endmodule

// File: doc/vram_dp.md
Name: vram_dp

Overview:
- Parametrised dual-port successor to the single-port VRAM.
- Port A is the host read/write port, with the same semantics as before. Port B is a read-only scanout port for the VGA timing/pixel pipeline.
- Channel bit-depth and depth are generalised.
- Adds a hardware fill engine that clears or paints the whole frame buffer without host writes.

Parameters:
- CH_W, 1, bits per colour channel (R, G, B each CH_W wide).
- ADDR_W, 14, address width; DEPTH = 2**ADDR_W words (default 16384 = 128x128).

Ports:
- clk  in  1  single clock for both ports and the fill engine.
- rst_n  in  1  asynchronous active-low reset.
- ENA  in  1  port A enable.
- WEA  in  1  port A write enable (qualified by ENA).
- SSRA  in  1  port A synchronous output clear (qualified by ENA).
- ADDRA  in  ADDR_W  port A address.
- DIA_R / DIA_G / DIA_B  in  CH_W each  port A write data.
- DOA_R / DOA_G / DOA_B  out  CH_W each  port A read data.
- ENB  in  1  port B (scanout) read enable.
- ADDRB  in  ADDR_W  port B address.
- DOB_R / DOB_G / DOB_B  out  CH_W each  port B read data.
- FILL_START  in  1  one-cycle request to start a fill.
- FILL_R / FILL_G / FILL_B  in  CH_W each  fill colour, sampled on an accepted FILL_START.
- FILL_BUSY  out  1  high while the fill engine owns the write path.
- FILL_DONE  out  1  one-cycle pulse when a fill completes.

Behaviour:
- Reset (rst_n low, async):
  - All DOA/DOB registers, FILL_BUSY and FILL_DONE go to 0.
  - FSM goes to IDLE; fill address goes to 0.
  - Memory contents are not cleared by reset.
- Storage: DEPTH words of 3*CH_W bits {R,G,B}; one inferred dual-port block RAM.
- Port A, latency 1, read-first. On the rising edge with ENA=1, priority is:
  - SSRA=1: DOA <= 0, and the write still occurs if WEA=1.
  - Otherwise DOA <= mem[ADDRA] (the old data).
  - If WEA=1, mem[ADDRA] <= DIA.
  - With ENA=0, DOA holds and no write occurs.
- Port B, latency 2, read-only:
  - Stage 1 registers ADDRB when ENB=1.
  - Stage 2 registers mem data into DOB.
  - The pipeline advances only when ENB=1; with ENB=0 both stages hold.
- Fill FSM: IDLE -> FILL -> DONE -> IDLE.
  - IDLE: FILL_START=1 latches the FILL_* colour, sets fill address to 0, goes to FILL, and raises FILL_BUSY on the next edge.
  - FILL: each cycle writes mem[fill_addr] <= fill colour and increments fill_addr. At fill_addr == DEPTH-1 it performs the write and goes to DONE. A fill takes exactly DEPTH write cycles.
  - DONE: FILL_BUSY <= 0, FILL_DONE = 1 for one cycle, then IDLE.
- While FILL_BUSY=1:
  - Port A writes are dropped (not queued).
  - Port A reads and SSRA still operate.
  - FILL_START is ignored.
  - Port B keeps reading, so scanout may show a partially filled frame.
- FILL_START arriving in the same cycle as a port A write in IDLE: the host write is performed, and the fill starts next cycle, so it overwrites that write.
- A fill address beyond DEPTH-1 is impossible; the address counter does not wrap.
- Reset mid-fill: the fill aborts, FILL_BUSY goes to 0 and no FILL_DONE is issued. Memory is left partially filled.
- Port A/B address collision (A writes X while B stage 1 reads X in the same cycle): see optional feature.

Optional Feature:
- Macro: VRAM_COLLISION_FWD_EN.
- Defined: on a collision, DOB returns the newly written data, forwarded from the port A/fill write data. This applies to both host and fill writes.
- Undefined: DOB returns the old memory contents (read-first on B). No forwarding logic is built.

Test Plan:
- Reset checks:
  - Drive rst_n=0 for 5 cycles mid-operation -> all DOA, DOB, FILL_BUSY and FILL_DONE are 0 immediately (async).
  - After release, a previously written word is still readable.
- Port A write/read with CH_W=1: ENA=1, WEA=1, ADDRA=257, DIA={1,0,1} -> DOA shows old data that cycle. Next read of 257 -> DOA={1,0,1} one cycle after the address.
- Port A SSRA: SSRA=1 with ENA=1, WEA=0 on address 257 -> DOA={0,0,0}. Then SSRA=0 -> DOA={1,0,1} again.
- Port B latency and stall:
  - Write 4097={0,1,1}, then ENB=1, ADDRB=4097 -> DOB={0,1,1} exactly 2 edges later.
  - Drop ENB for 3 cycles -> DOB holds.
- Fill with ADDR_W=4 (DEPTH=16):
  - FILL_START with colour {1,1,0} -> FILL_BUSY is high for 16 cycles, then FILL_DONE pulses once.
  - A port A write to address 3 during the fill is dropped.
  - Reading all 16 addresses returns {1,1,0}.
  - A second FILL_START during busy has no effect.
- Collision: same-cycle A write 4353={1,0,0} and B read 4353 (old value {0,0,0}) -> DOB={1,0,0} with VRAM_COLLISION_FWD_EN defined, {0,0,0} without.
